// File: rtl/vga_timing_pipe.sv
// VGA 640x480@60 timing generator with a pixel-tick-aligned delay line for
// sync/blank and a registered RGB output stage.
module vga_timing_pipe #(
  parameter int CLK_DIV     = 2,
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIPE_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_tick,
  output logic       frame_start,
  input  logic [3:0] Red_in,
  input  logic [3:0] Green_in,
  input  logic [3:0] Blue_in,
  output logic       hs,
  output logic       vs,
  output logic       blank_n,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [9:0]    hcnt;
  logic [9:0]    vcnt;
  logic          h_last;
  logic          v_last;
  logic          hs_raw;
  logic          vs_raw;
  logic          act_raw;
  logic          act_pre;
  logic [2:0]    pipe [PIPE_STAGES];

  assign pixel_tick  = (div_cnt == DIV_LAST);
  assign h_last      = (hcnt == H_LAST);
  assign v_last      = (vcnt == V_LAST);
  assign frame_start = pixel_tick && h_last && v_last;

  assign DrawX = hcnt;
  assign DrawY = vcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (pixel_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pixel_tick) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  always_comb begin
    hs_raw  = !((hcnt >= HS_START) && (hcnt < HS_END));
    vs_raw  = !((vcnt >= VS_START) && (vcnt < VS_END));
    act_raw = (hcnt < H_VIS) && (vcnt < V_VIS);
  end

  // Stage 0 holds the decode of the coordinate issued on the previous tick;
  // the last stage drives the pins. Reset fill is the idle {hs,vs,blank_n}.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PIPE_STAGES; i++) pipe[i] <= 3'b110;
    end else if (pixel_tick) begin
      pipe[0] <= {hs_raw, vs_raw, act_raw};
      for (int unsigned i = 1; i < PIPE_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {hs, vs, blank_n} = pipe[PIPE_STAGES-1];

  // RGB gates on the act bit that moves into the last stage on this tick,
  // so the colour register and blank_n always update together.
  generate
    if (PIPE_STAGES == 1) begin : g_act_direct
      assign act_pre = act_raw;
    end else begin : g_act_piped
      assign act_pre = pipe[PIPE_STAGES-2][0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else if (pixel_tick) begin
      Red   <= act_pre ? Red_in   : '0;
      Green <= act_pre ? Green_in : '0;
      Blue  <= act_pre ? Blue_in  : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe on a shrunken raster (30x15) so whole frames fit
// in a short run; reference model works from a flat tick count since reset.
module tb_vga_timing_pipe;

  localparam int CLK_DIV = 2;
  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int PS = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] DrawX, DrawY;
  logic       pixel_tick, frame_start;
  logic [3:0] Red_in = '0, Green_in = '0, Blue_in = '0;
  logic       hs, vs, blank_n;
  logic [3:0] Red, Green, Blue;

  vga_timing_pipe #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_STAGES(PS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .pixel_tick(pixel_tick), .frame_start(frame_start),
    .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
    .hs(hs), .vs(vs), .blank_n(blank_n),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int c        = 0;   // posedges since reset release
  int gcyc     = 0;   // posedges since start of run
  int mode     = 0;   // 0 random, 1 alignment, 2 constant F
  logic [11:0] exp_rgb = '0;
  int last_fs = -1;
  int act_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_total = 0;

  typedef struct {
    int   t;
    logic hs, vs, bl;
    int   x, y;
  } vec_t;
  vec_t tbl [14];

  function automatic int wrap(input int idx);
    return ((idx % FT) + FT) % FT;
  endfunction
  function automatic int xof(input int idx);
    return wrap(idx) % HT;
  endfunction
  function automatic int yof(input int idx);
    return wrap(idx) / HT;
  endfunction
  function automatic logic act_of(input int idx);
    if (idx < 0) return 1'b0;
    return (xof(idx) < HV) && (yof(idx) < VV);
  endfunction
  function automatic logic hs_of(input int idx);
    if (idx < 0) return 1'b1;
    return !((xof(idx) >= HV + HF) && (xof(idx) < HV + HF + HS));
  endfunction
  function automatic logic vs_of(input int idx);
    if (idx < 0) return 1'b1;
    return !((yof(idx) >= VV + VF) && (yof(idx) < VV + VF + VS));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_all();
    int   t;
    int   idx;
    logic tk;
    t   = c / CLK_DIV;
    idx = t % FT;
    tk  = (c % CLK_DIV) == CLK_DIV - 1;
    chk("DrawX", DrawX, xof(idx));
    chk("DrawY", DrawY, yof(idx));
    chk("pixel_tick", pixel_tick, tk);
    chk("frame_start", frame_start, tk && idx == FT - 1);
    chk("hs", hs, hs_of(t - PS));
    chk("vs", vs, vs_of(t - PS));
    chk("blank_n", blank_n, act_of(t - PS));
    chk("rgb", {Red, Green, Blue}, exp_rgb);
    if (mode == 1 && act_of(t - PS)) chk("align_red", Red, xof(t - PS) & 15);
    // per-frame tallies taken from what the pins actually show
    if (pixel_tick === 1'b1) begin
      act_cnt += int'(blank_n);
      hs_cnt  += int'(!hs);
      vs_cnt  += int'(!vs);
    end
    if (frame_start === 1'b1) begin
      fs_total++;
      if (last_fs >= 0) chk("frame_gap_clk", gcyc - last_fs, FT * CLK_DIV);
      chk("active_ticks_per_frame", act_cnt, HV * VV);
      chk("hs_low_ticks_per_frame", hs_cnt, HS * VT);
      chk("vs_low_ticks_per_frame", vs_cnt, VS * HT);
      last_fs = gcyc;
      act_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    end
  endtask

  task automatic step();
    int t;
    int xa;
    logic [11:0] v;
    t  = c / CLK_DIV;
    xa = xof(t - PS + 1);
    case (mode)
      1:       v = {xa[3:0], 8'($urandom)};
      2:       v = 12'hFFF;
      default: v = 12'($urandom);
    endcase
    {Red_in, Green_in, Blue_in} = v;
    if ((c % CLK_DIV) == CLK_DIV - 1) exp_rgb = act_of(t - PS + 1) ? v : 12'h000;
    @(posedge clk);
    c++;
    gcyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    c = 0;
    exp_rgb = '0;
    check_all();
    repeat (n) begin
      @(posedge clk);
      gcyc++;
    end
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    last_fs = gcyc - 1;
    act_cnt = 0; hs_cnt = 0; vs_cnt = 0;
  endtask

  initial begin
    int guard;
    int fs_before;
    tbl[0]  = '{0,   1'b1, 1'b1, 1'b0, 0,  0};
    tbl[1]  = '{1,   1'b1, 1'b1, 1'b0, 1,  0};
    tbl[2]  = '{2,   1'b1, 1'b1, 1'b1, 2,  0};
    tbl[3]  = '{17,  1'b1, 1'b1, 1'b1, 17, 0};
    tbl[4]  = '{18,  1'b1, 1'b1, 1'b0, 18, 0};
    tbl[5]  = '{22,  1'b0, 1'b1, 1'b0, 22, 0};
    tbl[6]  = '{27,  1'b0, 1'b1, 1'b0, 27, 0};
    tbl[7]  = '{28,  1'b1, 1'b1, 1'b0, 28, 0};
    tbl[8]  = '{31,  1'b1, 1'b1, 1'b0, 1,  1};
    tbl[9]  = '{32,  1'b1, 1'b1, 1'b1, 2,  1};
    tbl[10] = '{302, 1'b1, 1'b0, 1'b0, 2,  10};
    tbl[11] = '{361, 1'b1, 1'b0, 1'b0, 1,  12};
    tbl[12] = '{362, 1'b1, 1'b1, 1'b0, 2,  12};
    tbl[13] = '{452, 1'b1, 1'b1, 1'b1, 2,  0};

    @(negedge clk);
    mode = 2;
    do_reset(5);

    // hand-derived sync/blank/coordinate points with constant F pixels
    for (int i = 0; i < 14; i++) begin
      guard = 0;
      while (c / CLK_DIV < tbl[i].t && guard < 4000) begin
        step();
        guard++;
      end
      chk("tbl_tick_reached", c / CLK_DIV, tbl[i].t);
      chk("tbl_hs", hs, tbl[i].hs);
      chk("tbl_vs", vs, tbl[i].vs);
      chk("tbl_blank_n", blank_n, tbl[i].bl);
      chk("tbl_DrawX", DrawX, tbl[i].x);
      chk("tbl_DrawY", DrawY, tbl[i].y);
      chk("tbl_rgb", {Red, Green, Blue}, tbl[i].bl ? 12'hFFF : 12'h000);
    end

    mode = 0;
    repeat (3 * FT * CLK_DIV) step();
    mode = 1;
    repeat (FT * CLK_DIV) step();
    mode = 2;
    repeat (FT * CLK_DIV) step();

    // mid-frame reset at the scaled-down analogue of (700,300)
    mode = 0;
    guard = 0;
    while (!(xof(c / CLK_DIV) == 20 && yof(c / CLK_DIV) == 5 && (c % CLK_DIV) == 0)
           && guard < 2 * FT * CLK_DIV) begin
      step();
      guard++;
    end
    chk("midreset_pos_x", DrawX, 20);
    chk("midreset_pos_y", DrawY, 5);
    do_reset(3);
    chk("restart_x", DrawX, 0);
    chk("restart_y", DrawY, 0);
    fs_before = fs_total;
    repeat (FT * CLK_DIV + 10) step();
    chk("frame_starts_after_reset", fs_total - fs_before, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Drives DrawX/DrawY into the game-screen renderer.
- Registers the renderer's RGB back out to the VGA pins.
- Delays hsync/vsync/blank by a programmable number of pixel ticks, so the synchronous font-ROM latency inside the renderer stays aligned with the sync pulses.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz to 25 MHz).
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch (ticks).
- H_SYNC, 96, horizontal sync width (ticks).
- H_BP, 48, horizontal back porch (ticks).
- V_VISIBLE, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- PIPE_STAGES, 2, pixel-tick delay from DrawX/DrawY to the output pins (must be >= 1).

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  current horizontal counter (0..799)
- DrawY  out  10  current vertical counter (0..524)
- pixel_tick  out  1  one-clk pulse, pixel-rate enable
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)
- Red_in  in  4  renderer red for the pixel issued PIPE_STAGES-1 ticks earlier
- Green_in  in  4  renderer green
- Blue_in  in  4  renderer blue
- hs  out  1  horizontal sync, active low, delayed
- vs  out  1  vertical sync, active low, delayed
- blank_n  out  1  1 = active video, delayed
- Red  out  4  registered pixel red
- Green  out  4  registered pixel green
- Blue  out  4  registered pixel blue

Behaviour:
- Totals:
  - H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP = 800.
  - V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP = 525.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick = 1 for exactly the clk where div_cnt == CLK_DIV-1.
  - With CLK_DIV = 2, pixel_tick alternates 0/1 starting 0 after reset.
- Horizontal counter: on pixel_tick, hcnt increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - vcnt increments on the same tick as the hcnt wrap.
  - At V_TOTAL-1 (with hcnt wrap) it wraps to 0.
- DrawX = hcnt and DrawY = vcnt, registered; they change only on pixel_tick.
- frame_start = 1 on the clk where pixel_tick = 1, hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1 (the wrap tick). It is 0 otherwise.
- Raw sync and blank, decoded from current hcnt/vcnt:
  - hs_raw = 0 iff H_VISIBLE+H_FP <= hcnt < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs_raw = 0 iff V_VISIBLE+V_FP <= vcnt < V_VISIBLE+V_FP+V_SYNC (490..491).
  - act_raw = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE).
- Delay line:
  - {hs, vs, blank_n} come from a PIPE_STAGES-deep shift register of {hs_raw, vs_raw, act_raw}.
  - It shifts only on pixel_tick.
  - The output value at tick n equals the raw value for the coordinate issued at tick n-PIPE_STAGES.
- RGB output register:
  - Loads on pixel_tick.
  - Loads {Red_in, Green_in, Blue_in} if stage PIPE_STAGES-2 of the act delay line is 1 (act_raw itself when PIPE_STAGES = 1); otherwise loads 0.
  - This aligns with blank_n: RGB is always 0 whenever blank_n = 0.
- Stall behaviour: between ticks, every register holds its value.
- Reset (asynchronous, any time including mid-line or mid-frame):
  - div_cnt = 0, hcnt = 0, vcnt = 0, DrawX = 0, DrawY = 0.
  - pixel_tick = 0, frame_start = 0.
  - All delay stages are filled with hs = 1, vs = 1, blank_n = 0.
  - Red = Green = Blue = 0.
  - After release, counting restarts from (0,0) with no partial-frame recovery.
- Arithmetic: counters are 10 bits; compares are unsigned. No counter ever exceeds H_TOTAL-1 or V_TOTAL-1.

Test Plan:
- Reset check: hold reset_n = 0 for 5 clk, then release.
  - During reset: hs = 1, vs = 1, blank_n = 0, RGB = 0, DrawX = DrawY = 0.
  - First pixel_tick occurs at the 2nd clk after release.
- Line timing: count pixel_ticks across one line.
  - DrawX wraps 799 -> 0 and DrawY increments on the same tick.
  - hs low for exactly 96 ticks, with the falling edge PIPE_STAGES ticks after DrawX = 656.
- Frame timing:
  - frame_start pulses are spaced 420000 ticks (840000 clk) apart.
  - vs low for exactly 2 lines (1600 ticks), starting PIPE_STAGES ticks after (DrawX, DrawY) = (0, 490).
- Blanking: drive Red_in = Green_in = Blue_in = F constantly.
  - RGB output = F only while blank_n = 1; RGB = 0 otherwise.
  - Exactly 307200 active ticks per frame.
- Alignment: drive Red_in = DrawX[3:0] delayed by PIPE_STAGES-1 ticks.
  - Red output equals (delayed DrawX)[3:0] on every active pixel.
  - First active output pixel of a line has Red = 0.
- Mid-operation reset: assert reset_n = 0 at (DrawX, DrawY) = (700, 300) for 3 clk.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, DrawX/DrawY restart at (0,0).
  - Next frame_start arrives 420000 ticks later.
